// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared types and constants for the 4-way round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Arbiter FSM state encoding
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Default maximum number of cycles a single grant may stay valid
  localparam int unsigned C_MAX_HOLD_DEFAULT = 8;

  // Round-robin pointer advance: the requester after the one just served
  function automatic logic [1:0] f_next_ptr(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Brief    : Combinational round-robin winner select for 4 requesters.
//            Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_idx,
  output logic       o_any
);

  logic [1:0] w_cand;

  // Walk the search order backwards so the earliest set candidate wins
  always_comb begin
    o_idx  = i_ptr;
    o_any  = 1'b0;
    w_cand = i_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = i_ptr + 2'(k);
      if (i_req[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Brief    : 4-requester round-robin arbiter with hold limit. Drives the
//            select/enable of a downstream 2-to-4 decoder; all outputs are
//            registered. A grant always ends with at least one idle cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = C_MAX_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_req,
  input  logic       i_release,
  output logic [1:0] o_a,
  output logic       o_en,
  output logic       o_timeout
);

  // Counter sized to reach MAX_HOLD exactly; it is never incremented past it
  localparam int unsigned            C_CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [C_CNT_W-1:0]     C_MAX   = C_CNT_W'(MAX_HOLD);
  localparam logic [C_CNT_W-1:0]     C_ONE   = C_CNT_W'(1);

  state_t               r_state;
  logic [1:0]           r_ptr;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [1:0]           r_a;
  logic                 r_en;
  logic                 r_timeout;

  logic [1:0]           w_win;
  logic                 w_any;
  logic                 w_drop;
  logic                 w_limit;

  rr_pick4 u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_idx (w_win),
    .o_any (w_any)
  );

  // Owner-driven exit causes outrank the hold limit
  assign w_drop  = i_release | ~i_req[r_a];
  assign w_limit = (r_cnt == C_MAX);

  // Arbiter FSM with registered grant, enable and timeout outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= 2'd0;
      r_cnt     <= '0;
      r_a       <= 2'd0;
      r_en      <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= GRANT;
            r_a     <= w_win;
            r_en    <= 1'b1;
            r_cnt   <= C_ONE;
          end
        end
        GRANT: begin
          if (w_drop || w_limit) begin
            r_state   <= IDLE;
            r_en      <= 1'b0;
            r_ptr     <= f_next_ptr(r_a);
            r_cnt     <= '0;
            r_timeout <= ~w_drop;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign o_a       = r_a;
  assign o_en      = r_en;
  assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 The block SHALL have the parameter MAX_HOLD, default 8, setting the maximum number of cycles one grant holds en high (legal range 1..255).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req  input  4  per-requester request, level-sensitive; bit i = requester i.
REQ-006 release  input  1  the current owner is done, sampled only while en=1.
REQ-007 a  output  2  index of the granted requester; drives the select of the downstream 2-to-4 decoder.
REQ-008 en  output  1  grant valid; drives the enable of the downstream 2-to-4 decoder.
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 All outputs (a, en, timeout) SHALL be registered; no combinational path from any input to any output.
REQ-012 Round-robin pointer ptr (2 bits): search order ptr, ptr+1, ptr+2, ptr+3 mod 4; the first set req bit in that order wins.
REQ-013 IDLE: if req != 0 at edge N, go to GRANT; from edge N, a = winner, en = 1, hold count = 1.
REQ-014 IDLE with req == 0: stay in IDLE; en = 0; a holds its last value.
REQ-015 GRANT: stay while req[a]=1, release=0 and hold count < MAX_HOLD; the count increments by 1 each cycle.
REQ-016 GRANT exit: on release=1, on req[a]=0, or on hold count == MAX_HOLD. The next state is IDLE, with en = 0 after that edge.
REQ-017 On every GRANT exit, ptr SHALL become a+1 mod 4 (3 wraps to 0).
REQ-018 After a grant there is always at least one cycle with en = 0, so back-to-back grants are separated by exactly one idle cycle.
REQ-019 timeout SHALL be 1 for exactly the cycle after an exit caused only by the hold limit.
REQ-020 Simultaneous exit causes: release or req drop takes priority. If the hold limit is reached on the same edge, timeout SHALL remain 0.
REQ-021 A req change on a non-owner during GRANT SHALL have no effect until the next IDLE evaluation.
REQ-022 With MAX_HOLD=1, every grant SHALL last exactly one cycle, and timeout SHALL pulse unless release=1 or req[a]=0 on that edge.
REQ-023 The hold counter SHALL be wide enough for MAX_HOLD and SHALL never wrap.
REQ-024 a is only meaningful while en=1; the downstream stage SHALL treat a as don't-care when en=0.

Reset
REQ-025 rst=1 SHALL immediately set state=IDLE, a=0, en=0, timeout=0, ptr=0 and hold count=0, regardless of the clock.
REQ-026 Reset asserted during GRANT SHALL drop en within the same cycle (asynchronously); no pending timeout pulse survives.
REQ-027 After rst is released, the first grant SHALL follow REQ-013 with ptr=0.

Structure
REQ-028 The state encoding (IDLE=0, GRANT=1) and the MAX_HOLD default SHALL live in the shared package arb_pkg.
REQ-029 Winner selection SHALL be a combinational sub-module rr_pick4, with inputs req[3:0] and ptr[1:0] and outputs idx[1:0] and any.
REQ-030 The total RTL size SHALL be within 120-400 lines.

Verification
REQ-031 Reset state: assert rst with req=4'b1111 -> a=0, en=0 and timeout=0 while rst=1; on the first edge after release, a=0 and en=1.
REQ-032 Rotation: hold req=4'b1111 with release pulsed on the 2nd GRANT cycle -> grants to a = 0, 1, 2, 3, 0 in turn, each followed by one en=0 cycle.
REQ-033 Timeout: MAX_HOLD=8, req=4'b0100 held, release=0 -> en=1 with a=2 for 8 cycles, then en=0 and timeout=1 for one cycle; the next grant is to a=2 again.
REQ-034 Simultaneous events: release=1 on the same edge the hold count reaches MAX_HOLD -> en falls and timeout stays 0.
REQ-035 Mid-grant reset: assert rst during GRANT with a=3 -> en drops before the next clock edge; after release, ptr=0 and req=4'b1010 grants a=1.
REQ-036 Owner drop and wrap: granted a=3, req[3] deasserts -> en=0 next cycle; with req=4'b1001, the next grant is a=0 (ptr wrapped from 3 to 0).
